// File: rtl/pri_vblank_loader.sv
// Shadow register bank for the priority/colour mixer: CPU writes are buffered and marked dirty,
// then replayed into the mixer one register at a time on each vblank rising edge.
module pri_vblank_loader #(
    parameter int NUM_REGS   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_cs,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_addr,
    input  logic [1:0] cpu_ds_n,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       vblank,
    input  logic       resync,
    output logic       pri_cs,
    output logic       pri_rw,
    output logic [1:0] pri_ds_n,
    output logic [3:0] pri_addr,
    output logic [7:0] pri_din,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    state_t              state_reg, state_next;
    logic [3:0]          idx_reg, idx_next;
    logic [3:0]          gap_reg, gap_next;
    logic                vb_q_reg;
    logic [7:0]          cpu_dout_reg, cpu_dout_next;
    logic                pri_cs_reg, pri_cs_next;
    logic [3:0]          pri_addr_reg, pri_addr_next;
    logic [7:0]          pri_din_reg, pri_din_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                finish;

    logic [7:0]          shadow [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic [NUM_REGS-1:0] dirty_clr;

    logic cpu_wr;
    logic cpu_rd;
    logic start;
    logic unused_ds_hi;

    assign cpu_wr       = cpu_cs & ~cpu_rw & ~cpu_ds_n[0];
    assign cpu_rd       = cpu_cs & cpu_rw;
    assign start        = vblank & ~vb_q_reg;
    assign unused_ds_hi = cpu_ds_n[1];

    // Per-entry storage; a set (CPU write or resync) in the same cycle as a scan clear wins,
    // so a value changed while it is being replayed is sent again on the next pass.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [7:0] data_reg;
        logic       dirty_reg;
        logic       hit;

        assign hit = cpu_wr && (cpu_addr == 4'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_reg  <= 8'h00;
                dirty_reg <= 1'b0;
            end else begin
                if (hit) begin
                    data_reg <= cpu_din;
                end
                dirty_reg <= hit | resync | (dirty_reg & ~dirty_clr[gi]);
            end
        end

        assign shadow[gi] = data_reg;
        assign dirty[gi]  = dirty_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 4'd0;
            gap_reg      <= 4'd0;
            vb_q_reg     <= 1'b0;
            cpu_dout_reg <= 8'h00;
            pri_cs_reg   <= 1'b0;
            pri_addr_reg <= 4'd0;
            pri_din_reg  <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            gap_reg      <= gap_next;
            vb_q_reg     <= vblank;
            cpu_dout_reg <= cpu_dout_next;
            pri_cs_reg   <= pri_cs_next;
            pri_addr_reg <= pri_addr_next;
            pri_din_reg  <= pri_din_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        cpu_dout_next = cpu_rd ? shadow[cpu_addr] : cpu_dout_reg;
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        gap_next      = gap_reg;
        pri_cs_next   = 1'b0;
        pri_addr_next = pri_addr_reg;
        pri_din_next  = pri_din_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        dirty_clr     = '0;
        finish        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    idx_next   = 4'd0;
                    busy_next  = 1'b1;
                end
            end
            SCAN: begin
                if (dirty[idx_reg]) begin
                    pri_cs_next        = 1'b1;
                    pri_addr_next      = idx_reg;
                    pri_din_next       = shadow[idx_reg];
                    dirty_clr[idx_reg] = 1'b1;
                    gap_next           = GAP_LOAD;
                    state_next         = GAP;
                end else if (idx_reg == LAST_IDX) begin
                    finish = 1'b1;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            GAP: begin
                if (gap_reg <= 4'd1) begin
                    if (idx_reg == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = SCAN;
                    end
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (finish) begin
            state_next = IDLE;
            idx_next   = 4'd0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
        end
    end

    // rw and strobes follow the write pulse directly so an async reset clears them with it.
    assign pri_cs   = pri_cs_reg;
    assign pri_rw   = ~pri_cs_reg;
    assign pri_ds_n = pri_cs_reg ? 2'b10 : 2'b11;
    assign pri_addr = pri_addr_reg;
    assign pri_din  = pri_din_reg;
    assign cpu_dout = cpu_dout_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_pri_vblank_loader.sv
// Self-checking bench for pri_vblank_loader: a scoreboard of expected mixer writes is filled
// from a shadow/dirty model at each vblank and drained by a monitor on every pri_cs pulse.
`timescale 1ns/1ps
module tb_pri_vblank_loader;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_cs = 1'b0;
    logic       cpu_rw = 1'b1;
    logic [3:0] cpu_addr = 4'd0;
    logic [1:0] cpu_ds_n = 2'b11;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       vblank = 1'b0;
    logic       resync = 1'b0;
    logic       pri_cs;
    logic       pri_rw;
    logic [1:0] pri_ds_n;
    logic [3:0] pri_addr;
    logic [7:0] pri_din;
    logic       busy;
    logic       done;

    pri_vblank_loader #(.NUM_REGS(16), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_ds_n(cpu_ds_n),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .vblank(vblank), .resync(resync),
        .pri_cs(pri_cs), .pri_rw(pri_rw), .pri_ds_n(pri_ds_n), .pri_addr(pri_addr),
        .pri_din(pri_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  model_shadow [16];
    logic [15:0] model_dirty = '0;
    int          pulse_count = 0;
    int          busy_cycles = 0;
    int          done_count = 0;
    logic        prev_cs = 1'b0;
    logic [11:0] mon_exp;

    // Monitor: every mixer write pulse is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
        if (pri_cs === 1'b1) begin
            pulse_count++;
            checks++;
            if (prev_cs === 1'b1) begin
                errors++;
                $display("FAIL cs_spacing: pri_cs high on two consecutive cycles, addr %0d", pri_addr);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got addr %0d data %02h, expected no pulse", pri_addr, pri_din);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({pri_addr, pri_din} !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_content: got addr %0d data %02h, expected addr %0d data %02h",
                             pri_addr, pri_din, mon_exp[11:8], mon_exp[7:0]);
                end
            end
            checks++;
            if (pri_rw !== 1'b0 || pri_ds_n !== 2'b10) begin
                errors++;
                $display("FAIL pulse_strobes: got rw %b ds_n %b, expected rw 0 ds_n 10", pri_rw, pri_ds_n);
            end
        end else begin
            checks++;
            if (pri_rw !== 1'b1 || pri_ds_n !== 2'b11) begin
                errors++;
                $display("FAIL idle_strobes: got rw %b ds_n %b, expected rw 1 ds_n 11", pri_rw, pri_ds_n);
            end
        end
        prev_cs = pri_cs;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] ds);
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_din = d; cpu_ds_n = ds;
        @(posedge clk);
        #1;
        cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 2'b11;
        if (!ds[0]) begin
            model_shadow[a] = d;
            model_dirty[a]  = 1'b1;
        end
        $display("write reg %0d data %02h ds_n %b", a, d, ds);
    endtask

    task automatic cpu_read(input logic [3:0] a);
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = a; cpu_ds_n = 2'b00;
        @(posedge clk);
        #1;
        cpu_cs = 1'b0; cpu_ds_n = 2'b11;
        $display("read reg %0d -> %02h", a, cpu_dout);
    endtask

    function automatic int push_pass();
        int k = 0;
        for (int i = 0; i < 16; i++) begin
            if (model_dirty[i]) begin
                exp_q.push_back({4'(i), model_shadow[i]});
                model_dirty[i] = 1'b0;
                k++;
            end
        end
        return k;
    endfunction

    task automatic clear_counts();
        pulse_count = 0;
        busy_cycles = 0;
        done_count  = 0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < max_cycles && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic run_pass(input string name, input int exp_busy);
        int k;
        bit seen;
        k = push_pass();
        clear_counts();
        vblank = 1'b1;
        wait_done(200, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: no done pulse within 200 cycles", name);
        end
        checks++;
        if (busy_cycles != exp_busy) begin
            errors++;
            $display("FAIL %s_busy: got %0d busy cycles, expected %0d", name, busy_cycles, exp_busy);
        end
        checks++;
        if (pulse_count != k) begin
            errors++;
            $display("FAIL %s_pulses: got %0d pulses, expected %0d", name, pulse_count, k);
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, expected 1", name, done_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected pulses never seen", name, exp_q.size());
            exp_q.delete();
        end
        $display("pass %s: %0d pulses, busy %0d cycles, done %0d", name, pulse_count, busy_cycles, done_count);
        vblank = 1'b0;
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) model_shadow[i] = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_cpu_dout: got %02h, expected 00", cpu_dout); end
        checks++; if (pri_cs !== 1'b0) begin errors++; $display("FAIL reset_pri_cs: got %b, expected 0", pri_cs); end
        checks++; if (pri_rw !== 1'b1) begin errors++; $display("FAIL reset_pri_rw: got %b, expected 1", pri_rw); end
        checks++; if (pri_ds_n !== 2'b11) begin errors++; $display("FAIL reset_pri_ds_n: got %b, expected 11", pri_ds_n); end
        checks++; if (pri_addr !== 4'd0) begin errors++; $display("FAIL reset_pri_addr: got %0d, expected 0", pri_addr); end
        checks++; if (pri_din !== 8'h00) begin errors++; $display("FAIL reset_pri_din: got %02h, expected 00", pri_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        #1;
        reset_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_basic();
        cpu_write(4'd4, 8'h5A, 2'b00);
        cpu_write(4'd9, 8'h3C, 2'b00);
        run_pass("basic", 18);
    endtask

    task automatic test_readback();
        cpu_read(4'd9);
        checks++; if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL read_reg9: got %02h, expected 3c", cpu_dout); end
        step();
        checks++; if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL read_hold: got %02h, expected 3c", cpu_dout); end
        cpu_read(4'd4);
        checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL read_reg4: got %02h, expected 5a", cpu_dout); end
        cpu_write(4'd9, 8'hFF, 2'b01);
        cpu_read(4'd9);
        checks++; if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL masked_write: got %02h, expected 3c", cpu_dout); end
        run_pass("no_dirty", 16);
    endtask

    task automatic test_resync();
        resync = 1'b1;
        step();
        resync = 1'b0;
        model_dirty = '1;
        $display("resync pulse");
        run_pass("resync", 16 + 16 * GAP);
    endtask

    task automatic test_collision();
        int k;
        bit seen;
        cpu_write(4'd2, 8'h22, 2'b00);
        k = push_pass();
        clear_counts();
        vblank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Captured on the same edge at which SCAN issues register 2.
        cpu_write(4'd2, 8'h11, 2'b00);
        wait_done(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL collision_done: no done pulse within 200 cycles"); end
        checks++; if (pulse_count != k) begin errors++; $display("FAIL collision_pulses: got %0d, expected %0d", pulse_count, k); end
        checks++; if (busy_cycles != 16 + GAP) begin errors++; $display("FAIL collision_busy: got %0d, expected %0d", busy_cycles, 16 + GAP); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL collision_missing: %0d pulses never seen", exp_q.size()); exp_q.delete(); end
        $display("pass collision: %0d pulses, busy %0d cycles", pulse_count, busy_cycles);
        vblank = 1'b0;
        step();
        run_pass("collision_next", 16 + GAP);
    endtask

    task automatic test_vblank_hold();
        int k;
        bit seen;
        cpu_write(4'd7, 8'h77, 2'b00);
        k = push_pass();
        clear_counts();
        vblank = 1'b1;
        wait_done(200, seen);
        repeat (40) @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL hold_done: no done pulse within 200 cycles"); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL hold_retrigger: got %0d done pulses, expected 1", done_count); end
        checks++; if (pulse_count != k) begin errors++; $display("FAIL hold_pulses: got %0d, expected %0d", pulse_count, k); end
        checks++; if (busy_cycles != 16 + GAP) begin errors++; $display("FAIL hold_busy: got %0d, expected %0d", busy_cycles, 16 + GAP); end
        $display("pass hold: %0d pulses, %0d done pulses", pulse_count, done_count);
        vblank = 1'b0;
        step();

        cpu_write(4'd3, 8'h33, 2'b00);
        cpu_write(4'd12, 8'hC0, 2'b00);
        k = push_pass();
        clear_counts();
        vblank = 1'b1;
        repeat (4) step();
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        wait_done(200, seen);
        repeat (30) @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL busy_edge_done: no done pulse within 200 cycles"); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL busy_edge_restart: got %0d done pulses, expected 1", done_count); end
        checks++; if (pulse_count != k) begin errors++; $display("FAIL busy_edge_pulses: got %0d, expected %0d", pulse_count, k); end
        checks++; if (busy_cycles != 16 + 2 * GAP) begin errors++; $display("FAIL busy_edge_busy: got %0d, expected %0d", busy_cycles, 16 + 2 * GAP); end
        $display("pass busy_edge: %0d pulses, %0d done pulses", pulse_count, done_count);
        vblank = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int k;
        bit seen;
        cpu_write(4'd5, 8'h55, 2'b00);
        k = push_pass();
        clear_counts();
        vblank = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (pri_cs === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL areset_pulse: pri_cs never rose (expected %0d pulse)", k); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pri_cs !== 1'b0) begin errors++; $display("FAIL areset_pri_cs: got %b, expected 0", pri_cs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b, expected 0", busy); end
        checks++; if (pri_ds_n !== 2'b11) begin errors++; $display("FAIL areset_ds_n: got %b, expected 11", pri_ds_n); end
        checks++; if (pri_rw !== 1'b1) begin errors++; $display("FAIL areset_rw: got %b, expected 1", pri_rw); end
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done_count != 0) begin errors++; $display("FAIL areset_done: got %0d done pulses, expected 0", done_count); end
        exp_q.delete();
        model_dirty = '0;
        for (int i = 0; i < 16; i++) model_shadow[i] = 8'h00;
        #1;
        reset_n = 1'b1;
        step();
        cpu_read(4'd5);
        checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL areset_shadow: got %02h, expected 00", cpu_dout); end
        run_pass("after_reset", 16);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_readback();
        test_resync();
        test_collision();
        test_vblank_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
